// File: rtl/bitstream_sequencer.sv
// Frame scheduler feeding the bitstreamer: a small frame FIFO plus an IDLE/LOAD/SEND/GAP FSM.
// Optional BITSEQ_LOOP_EN writes every launched frame back to the FIFO tail so the pattern repeats.
module bitstream_sequencer #(
  parameter int DATALEN      = 64,
  parameter int CNTLEN       = 8,
  parameter int DEPTH        = 4,
  parameter int FRAME_CYCLES = 2048,
  parameter int GAPLEN       = 16,
  localparam int PW          = $clog2(DEPTH),
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATALEN-1:0] wr_data,
  input  logic [CNTLEN-1:0]  wr_phase,
  input  logic               arm,
  input  logic               abort,
  input  logic [GAPLEN-1:0]  gap,
  output logic [DATALEN-1:0] datain,
  output logic [CNTLEN-1:0]  phase_delay,
  output logic               bs_start,
  output logic               busy,
  output logic               frame_done,
  output logic [LW-1:0]      level,
  output logic               underrun,
  output logic [1:0]         dbg_state
);

  localparam int FCW = $clog2(FRAME_CYCLES);
  localparam int CW  = (FCW > GAPLEN) ? FCW : GAPLEN;
  localparam int FW  = DATALEN + CNTLEN;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, GAP = 2'd3} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [FW-1:0]   mem [DEPTH];
  logic [FW-1:0]   head;
  logic [FW-1:0]   mem_wdata;
  logic            push;
  logic            pop;
  logic            loop_wb;
  logic            mem_we;

  // Push handshake: a frame transfers on any clock edge where wr_valid && wr_ready;
  // wr_valid may be held while wr_ready is low and nothing is consumed until both are high.
  assign wr_ready  = (level < LW'(DEPTH)) && (state != LOAD);
  assign push      = wr_valid && wr_ready;
  assign pop       = (state == LOAD);
  assign head      = mem[rd_ptr];
  assign dbg_state = state;

`ifdef BITSEQ_LOOP_EN
  // An aborted LOAD discards its frame rather than recirculating it.
  assign loop_wb   = pop && !abort;
  assign mem_we    = push || loop_wb;
  assign mem_wdata = loop_wb ? head : {wr_data, wr_phase};
`else
  assign loop_wb   = 1'b0;
  assign mem_we    = push;
  assign mem_wdata = {wr_data, wr_phase};
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      datain      <= '0;
      phase_delay <= '0;
      bs_start    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (mem_we) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      if (push)                 level <= level + LW'(1);
      else if (pop && !loop_wb) level <= level - LW'(1);

      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        bs_start <= 1'b0;
        underrun <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm && level != '0) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            {datain, phase_delay} <= head;
            cnt      <= CW'(FRAME_CYCLES - 1);
            bs_start <= 1'b1;
            state    <= SEND;
          end
          SEND: begin
            // Raise frame_done one edge early so it lines up with the last bs_start clock.
            if (cnt == CW'(1)) frame_done <= 1'b1;
            if (cnt == '0) begin
              bs_start <= 1'b0;
              if (gap != '0) begin
                state <= GAP;
                cnt   <= CW'(gap) - CW'(1);
              end else if (arm && level != '0) begin
                state <= LOAD;
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                underrun <= underrun | arm;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          GAP: begin
            if (cnt == '0) begin
              if (arm && level != '0) begin
                state <= LOAD;
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                underrun <= underrun | arm;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitstream_sequencer.sv
// Directed bench for bitstream_sequencer: reset, single frame, gapped burst, abort,
// reset mid-frame and FIFO full; loop mode checks instead when BITSEQ_LOOP_EN is defined.
module tb_bitstream_sequencer;

  localparam int DATALEN      = 64;
  localparam int CNTLEN       = 8;
  localparam int DEPTH        = 4;
  localparam int FRAME_CYCLES = 2048;
  localparam int GAPLEN       = 16;
  localparam int LW           = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic               clk;
  logic               rst;
  logic               wr_valid;
  logic               wr_ready;
  logic [DATALEN-1:0] wr_data;
  logic [CNTLEN-1:0]  wr_phase;
  logic               arm;
  logic               abort;
  logic [GAPLEN-1:0]  gap;
  logic [DATALEN-1:0] datain;
  logic [CNTLEN-1:0]  phase_delay;
  logic               bs_start;
  logic               busy;
  logic               frame_done;
  logic [LW-1:0]      level;
  logic               underrun;
  logic [1:0]         dbg_state;

  int compared   = 0;
  int mismatched = 0;

  logic [71:0] exp_q[$];
  logic [71:0] exp_f;

  bitstream_sequencer #(
    .DATALEN(DATALEN), .CNTLEN(CNTLEN), .DEPTH(DEPTH),
    .FRAME_CYCLES(FRAME_CYCLES), .GAPLEN(GAPLEN)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_phase(wr_phase), .arm(arm), .abort(abort), .gap(gap),
    .datain(datain), .phase_delay(phase_delay), .bs_start(bs_start), .busy(busy),
    .frame_done(frame_done), .level(level), .underrun(underrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic push(input logic [71:0] f);
    wr_data  = f[71:8];
    wr_phase = f[7:0];
    wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_high(input string tag);
    int n;
    n = 0;
    while (bs_start !== 1'b1 && n < 200) begin
      n++;
      step(1);
    end
    check(tag, {63'd0, bs_start}, 64'd1);
  endtask

  task automatic measure_high(output int n, output int fd, output int fd_pos);
    n = 0; fd = 0; fd_pos = 0;
    while (bs_start === 1'b1 && n < 4000) begin
      n++;
      if (frame_done === 1'b1) begin
        fd++;
        fd_pos = n;
      end
      step(1);
    end
  endtask

  task automatic measure_low(output int n);
    n = 0;
    while (bs_start !== 1'b1 && n < 200) begin
      n++;
      step(1);
    end
  endtask

  task automatic check_frame(input string tag, input logic [71:0] f);
    check({tag, "_data"}, datain, f[71:8]);
    check({tag, "_phase"}, {56'd0, phase_delay}, {56'd0, f[7:0]});
  endtask

  // scoreboard-driven stimulus
  initial begin
    int n, fd, fdp;
    rst = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_phase = '0;
    arm = 1'b0; abort = 1'b0; gap = '0;
    step(2);
    check("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("rst_datain", datain, 64'd0);
    check("rst_phase", {56'd0, phase_delay}, 64'd0);
    check("rst_bs_start", {63'd0, bs_start}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_level", {61'd0, level}, 64'd0);
    check("rst_underrun", {63'd0, underrun}, 64'd0);
    check("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
    @(negedge clk) rst = 1'b1;
    step(1);

`ifdef BITSEQ_LOOP_EN
    exp_q.push_back({64'hF0F0_0000_0000_0001, 8'h21});
    exp_q.push_back({64'h0F0F_0000_0000_0002, 8'h42});
    push(exp_q[0]);
    push(exp_q[1]);
    check("loop_level_init", {61'd0, level}, 64'd2);
    arm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_high($sformatf("loop_launch%0d", i));
      exp_f = exp_q.pop_front();
      exp_q.push_back(exp_f);
      check_frame($sformatf("loop_f%0d", i), exp_f);
      check($sformatf("loop_level%0d", i), {61'd0, level}, 64'd2);
      if (i == 4) arm = 1'b0;
      measure_high(n, fd, fdp);
      check($sformatf("loop_len%0d", i), 64'(n), 64'(FRAME_CYCLES));
      check($sformatf("loop_underrun%0d", i), {63'd0, underrun}, 64'd0);
    end
    step(1);
    check("loop_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("loop_level_end", {61'd0, level}, 64'd2);
`else
    // single frame, arm dropped mid-frame so no underrun
    exp_f = {64'hA5A5_0000_FFFF_1234, 8'h10};
    push(exp_f);
    check("t1_level", {61'd0, level}, 64'd1);
    arm = 1'b1;
    step(1);
    check("t1_load_state", {62'd0, dbg_state}, {62'd0, S_LOAD});
    check("t1_load_bs", {63'd0, bs_start}, 64'd0);
    check("t1_load_wr_ready", {63'd0, wr_ready}, 64'd0);
    check("t1_load_busy", {63'd0, busy}, 64'd1);
    step(1);
    check("t1_bs_rise", {63'd0, bs_start}, 64'd1);
    check_frame("t1", exp_f);
    arm = 1'b0;
    measure_high(n, fd, fdp);
    check("t1_len", 64'(n), 64'(FRAME_CYCLES));
    check("t1_fd_count", 64'(fd), 64'd1);
    check("t1_fd_pos", 64'(fdp), 64'(FRAME_CYCLES));
    check("t1_busy_end", {63'd0, busy}, 64'd0);
    check("t1_level_end", {61'd0, level}, 64'd0);
    check("t1_underrun", {63'd0, underrun}, 64'd0);
    check_frame("t1_hold", exp_f);

    // three frames separated by gap=16
    exp_q.push_back({64'h1111_2222_3333_4444, 8'h01});
    exp_q.push_back({64'h5555_6666_7777_8888, 8'h02});
    exp_q.push_back({64'h9999_AAAA_BBBB_CCCC, 8'h03});
    foreach (exp_q[i]) push(exp_q[i]);
    check("t2_level", {61'd0, level}, 64'd3);
    gap = 16'd16;
    arm = 1'b1;
    wait_high("t2_launch");
    for (int i = 0; i < 3; i++) begin
      exp_f = exp_q.pop_front();
      check_frame($sformatf("t2_f%0d", i), exp_f);
      measure_high(n, fd, fdp);
      check($sformatf("t2_len%0d", i), 64'(n), 64'(FRAME_CYCLES));
      check($sformatf("t2_fd%0d", i), 64'(fd), 64'd1);
      if (i < 2) begin
        measure_low(n);
        check($sformatf("t2_low%0d", i), 64'(n), 64'd17);
      end
    end
    check("t2_in_gap", {62'd0, dbg_state}, {62'd0, S_GAP});
    check("t2_underrun_pre", {63'd0, underrun}, 64'd0);
    step(16);
    check("t2_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("t2_underrun", {63'd0, underrun}, 64'd1);
    check("t2_busy", {63'd0, busy}, 64'd0);
    arm = 1'b0;
    gap = '0;

    // abort 100 clocks into SEND with two frames queued
    push({64'hDEAD_BEEF_0000_0001, 8'hA1});
    push({64'hDEAD_BEEF_0000_0002, 8'hA2});
    arm = 1'b1;
    step(2);
    check("t3_bs_rise", {63'd0, bs_start}, 64'd1);
    arm = 1'b0;
    step(99);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t3_bs_drop", {63'd0, bs_start}, 64'd0);
    check("t3_fd", {63'd0, frame_done}, 64'd0);
    check("t3_level", {61'd0, level}, 64'd1);
    check("t3_underrun", {63'd0, underrun}, 64'd0);
    check("t3_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check_frame("t3_hold", {64'hDEAD_BEEF_0000_0001, 8'hA1});

    // reset asserted during SEND
    arm = 1'b1;
    wait_high("t4_launch");
    check_frame("t4", {64'hDEAD_BEEF_0000_0002, 8'hA2});
    step(50);
    arm = 1'b0;
    rst = 1'b0;
    #1;
    check("t4_bs", {63'd0, bs_start}, 64'd0);
    check("t4_datain", datain, 64'd0);
    check("t4_phase", {56'd0, phase_delay}, 64'd0);
    check("t4_busy", {63'd0, busy}, 64'd0);
    check("t4_level", {61'd0, level}, 64'd0);
    check("t4_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
    @(negedge clk) rst = 1'b1;
    step(1);

    // fill to DEPTH, push a fifth that must be dropped, then drain
    for (int i = 0; i < 5; i++) begin
      exp_f = {64'h0000_0000_C0DE_0000 + 64'(i), 8'(8'h50 + i)};
      if (i < 4) exp_q.push_back(exp_f);
      push(exp_f);
      check($sformatf("t5_level%0d", i), {61'd0, level}, 64'((i < 4) ? i + 1 : 4));
      check($sformatf("t5_ready%0d", i), {63'd0, wr_ready}, 64'((i < 3) ? 1 : 0));
    end
    arm = 1'b1;
    wait_high("t5_launch");
    for (int i = 0; i < 4; i++) begin
      exp_f = exp_q.pop_front();
      check_frame($sformatf("t5_f%0d", i), exp_f);
      if (i == 3) arm = 1'b0;
      measure_high(n, fd, fdp);
      check($sformatf("t5_len%0d", i), 64'(n), 64'(FRAME_CYCLES));
      if (i < 3) begin
        measure_low(n);
        check($sformatf("t5_low%0d", i), 64'(n), 64'd1);
      end
    end
    step(3);
    check("t5_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("t5_level_end", {61'd0, level}, 64'd0);
    check("t5_bs_end", {63'd0, bs_start}, 64'd0);
    check_frame("t5_hold", {64'h0000_0000_C0DE_0003, 8'h53});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
